bus_writeback: RTL and testbench
================================

// Module: bus_writeback
// PURPOSE
//   Receiving end of the datapath buses. Captures the S bus (shifter/ALU result)
//   into one of R0-R7, MDR or MAR, and loads MDR from the M bus (main memory)
//   through a request/acknowledge read handshake with timeout.
//   Its register outputs feed the transfer gates that drive the A and B buses.
// PARAMETERS
//   DW       16  data width of S bus, M bus and every destination register
//   TIMEOUT  15  max cycles in MEM_WAIT before giving up on mem_ack (1..255)
// PORTS
//   clk        in   1     single clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   S_bus      in   DW    result bus, sampled only on wb_req accept
//   M_bus      in   DW    memory data bus, sampled only on mem_ack in MEM_WAIT
//   wb_req     in   1     write S_bus to wb_dst (level; accepted when ready=1)
//   wb_dst     in   4     0-7 = R0-R7, 8 = MDR, 9 = MAR, 10-15 illegal
//   mem_req    in   1     load MDR from memory at address MAR (level)
//   mem_ack    in   1     memory read data valid on M_bus this cycle
//   mem_rd     out  1     read strobe to memory, high for all of MEM_WAIT
//   ra_q       out  DW x8 R0-R7 contents (unpacked [0:7]) to transfer gates
//   mdr_q      out  DW    MDR contents
//   mar_q      out  DW    MAR contents (memory address)
//   ready      out  1     1 iff state == IDLE
//   done       out  1     1-cycle pulse: write or memory load completed
//   err        out  1     1-cycle pulse: illegal wb_dst or memory timeout
// BEHAVIOUR
//   Reset: state IDLE; ra_q, mdr_q, mar_q = 0; mem_rd, done, err = 0; ready = 1.
//   States: IDLE, MEM_WAIT. The FSM has no other states.
//   IDLE, wb_req=1 (priority over mem_req): on this edge write S_bus to the
//     decoded destination; done=1 the next cycle; stay IDLE (back-to-back wb ok).
//     Illegal wb_dst: no register changes, err=1 next cycle, done=0.
//   IDLE, mem_req=1 and wb_req=0: -> MEM_WAIT, clear timeout counter; mem_rd=1
//     starting the next cycle. A mem_req held with wb_req waits (no loss).
//   MEM_WAIT: mem_ack=1 -> MDR <= M_bus, -> IDLE, done=1 next cycle.
//     Counter increments each cycle without mem_ack; on the cycle it reaches
//     TIMEOUT with no ack -> IDLE, err=1, MDR unchanged. An ack arriving on the
//     same cycle as expiry wins (load succeeds, no err).
//     wb_req/mem_req are ignored in MEM_WAIT (ready=0); no S_bus capture.
//   mem_ack outside MEM_WAIT is ignored. done and err are never both 1.
//   Async reset in MEM_WAIT: mem_rd drops immediately, all registers cleared.
//   Latency: S_bus write 1 cycle (value visible on *_q the cycle after accept);
//     memory load = ack cycle + 1.
// CONFIGURATION
//   FLAG_CAPTURE_EN defined: extra outputs flag_z (1), flag_n (1), reset 0,
//     updated on every successful S_bus write: flag_z = (S_bus==0),
//     flag_n = S_bus[DW-1]; unchanged by memory loads and illegal writes.
//   Undefined: ports flag_z/flag_n absent; no flag logic.
// STRUCTURE
//   bus_pkg: DW default, dest codes (DST_R0..DST_R7, DST_MDR=8, DST_MAR=9),
//     FSM state typedef {ST_IDLE, ST_MEM_WAIT}.
//   Sub-module reg_bank8: 8 x DW registers, one-hot write enable, async reset.
//   Top: dest decoder, FSM, timeout counter, MDR/MAR registers, pulse outputs.
// TESTING
//   1 wb_req, wb_dst=3, S_bus=16'hA5C3 -> ra_q[3]=A5C3 next cycle, done pulse,
//     other registers 0.
//   2 wb to R0..R7, MDR, MAR on consecutive cycles, data 16'h0001<<i -> each
//     lands once; ready stays 1; done high 10 consecutive cycles.
//   3 wb_dst=4'hC, S_bus=FFFF -> err pulse, no register change, done=0.
//   4 wb MAR=0040; mem_req; mem_ack on 3rd MEM_WAIT cycle with M_bus=1234
//     -> mem_rd high 3 cycles, mdr_q=1234, done pulse.
//   5 mem_req, no ack for TIMEOUT cycles -> err pulse, mdr_q unchanged, IDLE;
//     repeat with ack on expiry cycle -> done, no err.
//   6 rst asserted mid-MEM_WAIT -> mem_rd=0 same cycle, all *_q=0, ready=1;
//     wb_req+mem_req same cycle -> wb first, then MEM_WAIT.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus_writeback block: default data width,
// destination codes carried on wb_dst, and the writeback FSM state type.
package bus_pkg;

  localparam int DW_DEF = 16;

  // Destination codes on wb_dst; 10..15 are illegal.
  localparam logic [3:0] DST_R0  = 4'd0;
  localparam logic [3:0] DST_R1  = 4'd1;
  localparam logic [3:0] DST_R2  = 4'd2;
  localparam logic [3:0] DST_R3  = 4'd3;
  localparam logic [3:0] DST_R4  = 4'd4;
  localparam logic [3:0] DST_R5  = 4'd5;
  localparam logic [3:0] DST_R6  = 4'd6;
  localparam logic [3:0] DST_R7  = 4'd7;
  localparam logic [3:0] DST_MDR = 4'd8;
  localparam logic [3:0] DST_MAR = 4'd9;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MEM_WAIT = 1'b1
  } bus_state_e;

  // True when a wb_dst code names one of R0-R7.
  function automatic logic is_gpr(input logic [3:0] dst);
    return (dst[3] == 1'b0);
  endfunction

endpackage

// File: rtl/bus_writeback_if.sv
// Bus bundle between the datapath/memory side and bus_writeback.
// Optional feature macro: FLAG_CAPTURE_EN adds flag_z / flag_n.
//
// Handshake: wb_req and mem_req are levels; a request is taken on a rising
// clock edge where ready=1 (wb_req wins over mem_req). A request not taken
// must be held by the requester. mem_ack is a one-cycle data-valid strobe
// for M_bus, honoured only while mem_rd=1. done/err are one-cycle pulses
// reporting the outcome of the request taken on the previous edge.
interface bus_writeback_if #(parameter int DW = bus_pkg::DW_DEF);

  logic [DW-1:0]        S_bus;
  logic [DW-1:0]        M_bus;
  logic                 wb_req;
  logic [3:0]           wb_dst;
  logic                 mem_req;
  logic                 mem_ack;
  logic                 mem_rd;
  logic [DW-1:0]        ra_q [0:7];
  logic [DW-1:0]        mdr_q;
  logic [DW-1:0]        mar_q;
  logic                 ready;
  logic                 done;
  logic                 err;
  bus_pkg::bus_state_e  state_dbg;
`ifdef FLAG_CAPTURE_EN
  logic                 flag_z;
  logic                 flag_n;
`endif

  // Driven side: datapath, memory and testbench.
  modport master (
    output S_bus, M_bus, wb_req, wb_dst, mem_req, mem_ack,
    input  mem_rd, ra_q, mdr_q, mar_q, ready, done, err, state_dbg
`ifdef FLAG_CAPTURE_EN
    , input flag_z, flag_n
`endif
  );

  // Receiving side: bus_writeback itself.
  modport slave (
    input  S_bus, M_bus, wb_req, wb_dst, mem_req, mem_ack,
    output mem_rd, ra_q, mdr_q, mar_q, ready, done, err, state_dbg
`ifdef FLAG_CAPTURE_EN
    , output flag_z, flag_n
`endif
  );

endinterface

// File: rtl/bus_writeback_reg_bank8.sv
// reg_bank8: eight DW-bit general registers R0-R7 with a one-hot write
// enable and a shared write data port. Asynchronous active-high reset.
module reg_bank8 #(
  parameter int DW = bus_pkg::DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    we_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] q_o [0:7]
);

  logic [DW-1:0] r_q [0:7];

  // Each register loads wdata_i when its enable bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (we_i[i]) r_q[i] <= wdata_i;
      end
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/bus_writeback.sv
// bus_writeback: captures the S bus into R0-R7/MDR/MAR and loads MDR from
// the M bus through a mem_rd/mem_ack read with timeout.
// Optional feature macro: FLAG_CAPTURE_EN (zero/negative flags of the last
// successful S bus write).
module bus_writeback
  import bus_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  bus_writeback_if.slave bw
);

  bus_state_e    state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] mdr_q, mar_q;
  logic [DW-1:0] ra_w [0:7];

  logic          wb_accept;
  logic [7:0]    we_ra;
  logic          we_mdr;
  logic          we_mar;
  logic          dst_illegal;
  logic          mdr_load;

  // A write is taken only in IDLE; MEM_WAIT ignores wb_req entirely.
  assign wb_accept = (state_q == ST_IDLE) && bw.wb_req;

  // Destination decoder: one-hot enables for the accepted write.
  always_comb begin
    we_ra       = '0;
    we_mdr      = 1'b0;
    we_mar      = 1'b0;
    dst_illegal = 1'b0;
    if (wb_accept) begin
      if (is_gpr(bw.wb_dst)) begin
        we_ra = 8'b1 << bw.wb_dst[2:0];
      end else if (bw.wb_dst == DST_MDR) begin
        we_mdr = 1'b1;
      end else if (bw.wb_dst == DST_MAR) begin
        we_mar = 1'b1;
      end else begin
        dst_illegal = 1'b1;
      end
    end
  end

  // FSM next state, timeout counter and completion pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mdr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bw.wb_req) begin
          done_d = ~dst_illegal;
          err_d  = dst_illegal;
        end else if (bw.mem_req) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = '0;
        end
      end
      ST_MEM_WAIT: begin
        // An ack on the expiry cycle still counts as a successful load.
        if (bw.mem_ack) begin
          mdr_load = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, counter and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // MDR takes S_bus writes in IDLE and M_bus data on ack; MAR only S_bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdr_q <= '0;
      mar_q <= '0;
    end else begin
      if (we_mdr)        mdr_q <= bw.S_bus;
      else if (mdr_load) mdr_q <= bw.M_bus;
      if (we_mar)        mar_q <= bw.S_bus;
    end
  end

  reg_bank8 #(.DW(DW)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_ra),
    .wdata_i (bw.S_bus),
    .q_o     (ra_w)
  );

`ifdef FLAG_CAPTURE_EN
  logic flag_z_q, flag_n_q;
  logic wb_ok;

  assign wb_ok = wb_accept && !dst_illegal;

  // Flags follow every successful S bus write and nothing else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (wb_ok) begin
      flag_z_q <= (bw.S_bus == '0);
      flag_n_q <= bw.S_bus[DW-1];
    end
  end

  assign bw.flag_z = flag_z_q;
  assign bw.flag_n = flag_n_q;
`endif

  // mem_rd decodes straight from state so an async reset drops it at once.
  assign bw.mem_rd    = (state_q == ST_MEM_WAIT);
  assign bw.ready     = (state_q == ST_IDLE);
  assign bw.done      = done_q;
  assign bw.err       = err_q;
  assign bw.mdr_q     = mdr_q;
  assign bw.mar_q     = mar_q;
  assign bw.ra_q      = ra_w;
  assign bw.state_dbg = state_q;

endmodule

// File: tb/tb_bus_writeback.sv
// Directed testbench for bus_writeback with a reference register model and
// an expected-data queue.
module tb_bus_writeback;
  import bus_pkg::*;

  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_ra [0:7];
  logic [DW-1:0] m_mdr;
  logic [DW-1:0] m_mar;
  int            rd_cycles;

  bus_writeback_if #(.DW(DW)) bw ();

  bus_writeback #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bw  (bw)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one edge; everything after tick runs 1 time unit past posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bw.wb_req  = 1'b0;
    bw.wb_dst  = 4'd0;
    bw.S_bus   = '0;
    bw.mem_req = 1'b0;
    bw.mem_ack = 1'b0;
    bw.M_bus   = '0;
  endtask

  // Drive one write request and record its effect in the model/queue.
  task automatic drive_wb(input logic [3:0] dst, input logic [DW-1:0] data);
    bw.wb_req = 1'b1;
    bw.wb_dst = dst;
    bw.S_bus  = data;
    if (dst < 4'd8)       m_ra[dst[2:0]] = data;
    else if (dst == 4'd8) m_mdr = data;
    else if (dst == 4'd9) m_mar = data;
    if (dst <= 4'd9) exp_q.push_back(data);
  endtask

  function automatic logic [DW-1:0] dest_value(input logic [3:0] dst);
    if (dst < 4'd8)  return bw.ra_q[dst[2:0]];
    if (dst == 4'd8) return bw.mdr_q;
    return bw.mar_q;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_r%0d", tag, i), 32'(bw.ra_q[i]), 32'(m_ra[i]));
    check({tag, "_mdr"}, 32'(bw.mdr_q), 32'(m_mdr));
    check({tag, "_mar"}, 32'(bw.mar_q), 32'(m_mar));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_ra[i] = '0;
    m_mdr = '0;
    m_mar = '0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ready", 32'(bw.ready), 32'd1);
    check("rst_mem_rd", 32'(bw.mem_rd), 32'd0);
    check("rst_done", 32'(bw.done), 32'd0);
    check("rst_err", 32'(bw.err), 32'd0);
    check_all("rst");

    // 1: single write to R3
    drive_wb(4'd3, 16'hA5C3);
    tick();
    idle_inputs();
    check("t1_done", 32'(bw.done), 32'd1);
    check("t1_err", 32'(bw.err), 32'd0);
    pop_check("t1_r3", bw.ra_q[3]);
    check_all("t1");
`ifdef FLAG_CAPTURE_EN
    check("t1_flag_z", 32'(bw.flag_z), 32'd0);
    check("t1_flag_n", 32'(bw.flag_n), 32'd1);
`endif
    tick();
    check("t1_done_drop", 32'(bw.done), 32'd0);

    // 2: back-to-back writes to every destination
    for (int i = 0; i < 10; i++) begin
      drive_wb(4'(i), 16'h0001 << i);
      tick();
      check($sformatf("t2_done_%0d", i), 32'(bw.done), 32'd1);
      check($sformatf("t2_ready_%0d", i), 32'(bw.ready), 32'd1);
      pop_check($sformatf("t2_dst_%0d", i), dest_value(4'(i)));
    end
    idle_inputs();
    check_all("t2");
    tick();
    check("t2_done_drop", 32'(bw.done), 32'd0);

    // 3: illegal destination
    drive_wb(4'hC, 16'hFFFF);
    tick();
    idle_inputs();
    check("t3_err", 32'(bw.err), 32'd1);
    check("t3_done", 32'(bw.done), 32'd0);
    check_all("t3");
    tick();
    check("t3_err_drop", 32'(bw.err), 32'd0);

    // mem_ack while IDLE is ignored
    bw.mem_ack = 1'b1;
    bw.M_bus   = 16'hDEAD;
    tick();
    idle_inputs();
    check("idle_ack_done", 32'(bw.done), 32'd0);
    check("idle_ack_mdr", 32'(bw.mdr_q), 32'(m_mdr));

    // 4: MAR then memory load acked on the third MEM_WAIT cycle
    drive_wb(4'd9, 16'h0040);
    tick();
    idle_inputs();
    pop_check("t4_mar", bw.mar_q);
    bw.mem_req = 1'b1;
    tick();
    bw.mem_req = 1'b0;
    rd_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      if (bw.mem_rd) rd_cycles++;
      if (c == 3) begin
        bw.mem_ack = 1'b1;
        bw.M_bus   = 16'h1234;
        m_mdr      = 16'h1234;
        exp_q.push_back(16'h1234);
      end
      tick();
    end
    idle_inputs();
    check("t4_rd_cycles", 32'(rd_cycles), 32'd3);
    check("t4_mem_rd_off", 32'(bw.mem_rd), 32'd0);
    check("t4_done", 32'(bw.done), 32'd1);
    check("t4_err", 32'(bw.err), 32'd0);
    pop_check("t4_mdr", bw.mdr_q);
    check("t4_mar_keep", 32'(bw.mar_q), 32'h0040);

    // 5a: timeout, no ack
    bw.mem_req = 1'b1;
    tick();
    bw.mem_req = 1'b0;
    rd_cycles = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (bw.mem_rd) rd_cycles++;
      if (c < TIMEOUT && bw.done !== 1'b0) check("t5_early_done", 32'(bw.done), 32'd0);
      tick();
    end
    check("t5_rd_cycles", 32'(rd_cycles), TIMEOUT);
    check("t5_err", 32'(bw.err), 32'd1);
    check("t5_done", 32'(bw.done), 32'd0);
    check("t5_ready", 32'(bw.ready), 32'd1);
    check("t5_mdr_keep", 32'(bw.mdr_q), 32'(m_mdr));

    // 5b: ack on the expiry cycle wins
    bw.mem_req = 1'b1;
    tick();
    bw.mem_req = 1'b0;
    for (int c = 1; c < TIMEOUT; c++) tick();
    check("t5b_still_wait", 32'(bw.mem_rd), 32'd1);
    bw.mem_ack = 1'b1;
    bw.M_bus   = 16'hBEEF;
    m_mdr      = 16'hBEEF;
    exp_q.push_back(16'hBEEF);
    tick();
    idle_inputs();
    check("t5b_done", 32'(bw.done), 32'd1);
    check("t5b_err", 32'(bw.err), 32'd0);
    pop_check("t5b_mdr", bw.mdr_q);

    // 6a: async reset in the middle of MEM_WAIT
    bw.mem_req = 1'b1;
    tick();
    bw.mem_req = 1'b0;
    check("t6_mem_rd_on", 32'(bw.mem_rd), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_mem_rd_async", 32'(bw.mem_rd), 32'd0);
    check("t6_ready_async", 32'(bw.ready), 32'd1);
    check_all("t6_rst");
    #1;
    rst = 1'b0;
    tick();

    // 6b: wb and mem requests together: write first, then MEM_WAIT
    drive_wb(4'd1, 16'h0077);
    bw.mem_req = 1'b1;
    tick();
    bw.wb_req = 1'b0;
    check("t6_wb_done", 32'(bw.done), 32'd1);
    check("t6_wb_ready", 32'(bw.ready), 32'd1);
    pop_check("t6_r1", bw.ra_q[1]);
    tick();
    bw.mem_req = 1'b0;
    check("t6_mem_rd", 32'(bw.mem_rd), 32'd1);
    check("t6_ready_wait", 32'(bw.ready), 32'd0);
    // write attempt during MEM_WAIT must be dropped
    bw.wb_req  = 1'b1;
    bw.wb_dst  = 4'd2;
    bw.S_bus   = 16'h9999;
    bw.mem_ack = 1'b1;
    bw.M_bus   = 16'h5555;
    m_mdr      = 16'h5555;
    exp_q.push_back(16'h5555);
    tick();
    idle_inputs();
    check("t6_ld_done", 32'(bw.done), 32'd1);
    pop_check("t6_mdr", bw.mdr_q);
    check_all("t6_end");
    check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
